// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display block.
// Contents: digit geometry, scan FSM state encoding, write requester IDs and
// a helper producing the active-low anode pattern for a digit index.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_SW  = 1'b1
  } req_id_e;

  // Active-low anode enables with only the selected digit driven low.
  function automatic logic [NUM_DIGITS-1:0] an_for_digit(input logic [1:0] idx);
    an_for_digit = ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_wr_arb.sv
// Two-way round-robin arbiter for the digit buffer write port.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cpu_req_i, sw_req_i   requests, held by the requester until its grant
//   cpu_win_o, sw_win_o   combinational: this requester commits at the coming edge
//   cpu_gnt_o, sw_gnt_o   registered one-cycle grant pulses following the commit
module seg_wr_arb
  import seg_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpu_req_i,
  input  logic sw_req_i,
  output logic cpu_win_o,
  output logic sw_win_o,
  output logic cpu_gnt_o,
  output logic sw_gnt_o
);

  logic    cpu_gnt_q, sw_gnt_q;
  req_id_e rr_last_q;
  logic    cpu_elig, sw_elig, contend;

  // A request seen while its own grant is high is the tail of the committed
  // one, so it is not eligible again until the grant drops.
  assign cpu_elig  = cpu_req_i & ~cpu_gnt_q;
  assign sw_elig   = sw_req_i & ~sw_gnt_q;
  assign contend   = cpu_elig & sw_elig;
  assign cpu_win_o = cpu_elig & (~sw_elig | (rr_last_q == REQ_SW));
  assign sw_win_o  = sw_elig & ~cpu_win_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cpu_gnt_q <= 1'b0;
      sw_gnt_q  <= 1'b0;
      rr_last_q <= REQ_SW;
    end else begin
      cpu_gnt_q <= cpu_win_o;
      sw_gnt_q  <= sw_win_o;
      // Priority only rotates when both sides actually contended.
      if (contend) begin
        rr_last_q <= cpu_win_o ? REQ_CPU : REQ_SW;
      end
    end
  end

  assign cpu_gnt_o = cpu_gnt_q;
  assign sw_gnt_o  = sw_gnt_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller and write arbiter for a 4-digit multiplexed seven-segment display.
// Holds a 4x4-bit digit buffer written by the CPU (one digit) or the switches (all
// digits), and time-multiplexes it onto one hex decoder with blanking between digits.
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   cpu_req/digit/data, gnt   single-digit write, gnt pulses once when committed
//   sw_req/data, sw_gnt       bulk 16-bit load, digit3..0 = sw_data[15:12]..[3:0]
//   digit_val                 nibble of the digit currently lit
//   AN                        active-low anode enables, at most one low
//   scan_idx                  index of the digit currently scanned
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIV       = 50_000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_digit,
  input  logic [3:0]  cpu_data,
  output logic        cpu_gnt,
  input  logic        sw_req,
  input  logic [15:0] sw_data,
  output logic        sw_gnt,
  output logic [3:0]  digit_val,
  output logic [3:0]  AN,
  output logic [1:0]  scan_idx
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] OnLast    = CntW'(DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_q;
  scan_state_e                        state_q;
  logic [CntW-1:0]                    cnt_q;
  logic [1:0]                         scan_idx_q;
  logic [DIGIT_W-1:0]                 digit_val_q;
  logic [NUM_DIGITS-1:0]              an_q;
  logic                               cpu_win, sw_win;

  seg_wr_arb u_wr_arb (
    .clk_i     (CLK),
    .rst_i     (RST),
    .cpu_req_i (cpu_req),
    .sw_req_i  (sw_req),
    .cpu_win_o (cpu_win),
    .sw_win_o  (sw_win),
    .cpu_gnt_o (cpu_gnt),
    .sw_gnt_o  (sw_gnt)
  );

  // The arbiter guarantees at most one winner per edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      digits_q <= '0;
    end else if (cpu_win) begin
      digits_q[cpu_digit] <= cpu_data;
    end else if (sw_win) begin
      digits_q <= sw_data;
    end
  end

  // Scan FSM. digit_val is captured only at BLANK->ON so a digit never changes
  // while lit; a write landing on that same edge is seen on the next frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      scan_idx_q  <= '0;
      digit_val_q <= '0;
      an_q        <= '1;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BlankLast) begin
            state_q     <= ST_ON;
            cnt_q       <= '0;
            digit_val_q <= digits_q[scan_idx_q];
            an_q        <= an_for_digit(scan_idx_q);
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        ST_ON: begin
          if (cnt_q == OnLast) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            scan_idx_q <= scan_idx_q + 2'd1;
            an_q       <= '1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= ST_BLANK;
          cnt_q   <= '0;
          an_q    <= '1;
        end
      endcase
    end
  end

  assign digit_val = digit_val_q;
  assign AN        = an_q;
  assign scan_idx  = scan_idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DIV=4, BLANK_CYC=1.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [1:0]  cpu_digit = 2'd0;
  logic [3:0]  cpu_data = 4'h0;
  logic        sw_req = 1'b0;
  logic [15:0] sw_data = 16'h0;
  logic        cpu_gnt, sw_gnt;
  logic [3:0]  digit_val, an;
  logic [1:0]  scan_idx;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(
    .DIV       (4),
    .BLANK_CYC (1)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .cpu_req   (cpu_req),
    .cpu_digit (cpu_digit),
    .cpu_data  (cpu_data),
    .cpu_gnt   (cpu_gnt),
    .sw_req    (sw_req),
    .sw_data   (sw_data),
    .sw_gnt    (sw_gnt),
    .digit_val (digit_val),
    .AN        (an),
    .scan_idx  (scan_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [1:0] idx;
    int         len;
  } scan_step_t;

  typedef struct {
    logic        cpu_req;
    logic [1:0]  cpu_digit;
    logic [3:0]  cpu_data;
    logic        sw_req;
    logic [15:0] sw_data;
    logic        exp_cg;
    logic        exp_sg;
  } arb_vec_t;

  scan_step_t scan_tbl[8];
  arb_vec_t   arb_tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each row: drive at a falling edge, commit on the rising edge, sample grants
  // at the next falling edge.
  task automatic apply_arb(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cpu_req   = arb_tbl[i].cpu_req;
      cpu_digit = arb_tbl[i].cpu_digit;
      cpu_data  = arb_tbl[i].cpu_data;
      sw_req    = arb_tbl[i].sw_req;
      sw_data   = arb_tbl[i].sw_data;
      @(negedge clk);
      chk($sformatf("arb%0d_cpu_gnt", i), cpu_gnt, arb_tbl[i].exp_cg);
      chk($sformatf("arb%0d_sw_gnt", i), sw_gnt, arb_tbl[i].exp_sg);
    end
    cpu_req = 1'b0;
    sw_req  = 1'b0;
  endtask

  // Wait for a fresh ON period of the digit with anode pattern an_t, then check digit_val.
  task automatic show_digit(input string name, input logic [3:0] an_t, input logic [3:0] exp);
    bit found = 0;
    for (int n = 0; n < 60; n++) begin
      if (an !== an_t) break;
      @(negedge clk);
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (an === an_t) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: AN never reached %b, got %b", name, an_t, an);
    end else begin
      chk(name, digit_val, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit found;

    scan_tbl[0] = '{4'b1110, 2'd0, 4};
    scan_tbl[1] = '{4'b1111, 2'd1, 1};
    scan_tbl[2] = '{4'b1101, 2'd1, 4};
    scan_tbl[3] = '{4'b1111, 2'd2, 1};
    scan_tbl[4] = '{4'b1011, 2'd2, 4};
    scan_tbl[5] = '{4'b1111, 2'd3, 1};
    scan_tbl[6] = '{4'b0111, 2'd3, 4};
    scan_tbl[7] = '{4'b1111, 2'd0, 1};

    // cpu write, idle, sw load, idle, then two contention rounds
    arb_tbl[0] = '{1'b1, 2'd2, 4'hA, 1'b0, 16'h0000, 1'b1, 1'b0};
    arb_tbl[1] = '{1'b0, 2'd0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0};
    arb_tbl[2] = '{1'b0, 2'd0, 4'h0, 1'b1, 16'h1234, 1'b0, 1'b1};
    arb_tbl[3] = '{1'b0, 2'd0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0};
    arb_tbl[4] = '{1'b1, 2'd0, 4'h5, 1'b1, 16'h1234, 1'b1, 1'b0};
    arb_tbl[5] = '{1'b0, 2'd0, 4'h5, 1'b1, 16'h1234, 1'b0, 1'b1};
    arb_tbl[6] = '{1'b0, 2'd0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0};
    arb_tbl[7] = '{1'b1, 2'd1, 4'h3, 1'b1, 16'h1204, 1'b0, 1'b1};
    arb_tbl[8] = '{1'b1, 2'd1, 4'h3, 1'b0, 16'h1204, 1'b1, 1'b0};
    arb_tbl[9] = '{1'b0, 2'd0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0};

    // 1. Reset state and one full scan frame
    @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_digit_val", digit_val, 4'h0);
    chk("rst_scan_idx", scan_idx, 2'd0);
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_sw_gnt", sw_gnt, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_blank_an", an, 4'hF);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < scan_tbl[s].len; c++) begin
        @(negedge clk);
        chk($sformatf("scan%0d_%0d_an", s, c), an, scan_tbl[s].an);
        chk($sformatf("scan%0d_%0d_idx", s, c), scan_idx, scan_tbl[s].idx);
        chk($sformatf("scan%0d_%0d_dv", s, c), digit_val, 4'h0);
      end
    end
    @(negedge clk);
    chk("wrap_an", an, 4'b1110);
    chk("wrap_idx", scan_idx, 2'd0);

    // 2. CPU write digit2 = A
    apply_arb(0, 1);
    show_digit("t2_d2", 4'b1011, 4'hA);
    show_digit("t2_d3", 4'b0111, 4'h0);
    show_digit("t2_d0", 4'b1110, 4'h0);
    show_digit("t2_d1", 4'b1101, 4'h0);

    // 3. Bulk load 1234
    apply_arb(2, 3);
    show_digit("t3_d0", 4'b1110, 4'h4);
    show_digit("t3_d1", 4'b1101, 4'h3);
    show_digit("t3_d2", 4'b1011, 4'h2);
    show_digit("t3_d3", 4'b0111, 4'h1);

    // 4. Contention: CPU first (rr_last=SW after reset), then SW first
    apply_arb(4, 9);

    // 5. CPU write digit1 = F on the edge digit1 latches
    found = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (an === 4'hF && scan_idx === 2'd1) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL t5_wait: blank before digit1 not seen, AN=%b idx=%0d", an, scan_idx);
    end
    cpu_req   = 1'b1;
    cpu_digit = 2'd1;
    cpu_data  = 4'hF;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("t5_cpu_gnt", cpu_gnt, 1'b1);
    chk("t5_an", an, 4'b1101);
    chk("t5_old_val", digit_val, 4'h3);
    show_digit("t5_new_val", 4'b1101, 4'hF);

    // 6. Reset during ON of digit2 with a CPU request pending
    show_digit("t6_pre_d2", 4'b1011, 4'h2);
    cpu_req   = 1'b1;
    cpu_digit = 2'd3;
    cpu_data  = 4'h7;
    rst       = 1'b1;
    #1;
    chk("t6_an_async", an, 4'hF);
    chk("t6_cpu_gnt", cpu_gnt, 1'b0);
    chk("t6_idx", scan_idx, 2'd0);
    chk("t6_dv", digit_val, 4'h0);
    @(posedge clk);
    #1;
    chk("t6_cpu_gnt_held", cpu_gnt, 1'b0);
    @(negedge clk);
    cpu_req = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    chk("t6_restart_an", an, 4'b1110);
    chk("t6_restart_idx", scan_idx, 2'd0);
    chk("t6_d0", digit_val, 4'h0);
    show_digit("t6_d1", 4'b1101, 4'h0);
    show_digit("t6_d2", 4'b1011, 4'h0);
    show_digit("t6_d3", 4'b0111, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
